// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, status layout, bus addresses and helpers for the UART RX path
package uart_pkg;

    typedef enum logic [1:0] {
        WAIT_FLAG,
        CAPTURE,
        CLEAR,
        WAIT_DROP
    } rx_state_t;

    localparam int ST_NEMPTY  = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVR     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam logic [31:0] UART_RX_DATA_ADDR = 32'h1001_0028;
    localparam logic [31:0] UART_RX_STAT_ADDR = 32'h1001_002C;

    function automatic int CeilLog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous receive FIFO with occupancy count
// Ports: clk, reset (async, active-high), push/pop strobes, wr_data in,
//        head (oldest entry), count (0..FIFO_DEPTH), full, empty.
// A push while full is only accepted when a pop frees a slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int NBIT       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = CeilLog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [NBIT-1:0]  wr_data,
    output logic [NBIT-1:0]  head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = CeilLog2(FIFO_DEPTH);

    logic [NBIT-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = count == '0;
    assign full    = count == CNT_W'(FIFO_DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign head    = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so power-of-2 depth wraps for free
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wr_data;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences UART_RX bytes into a receive FIFO and maps it onto the CPU bus
// Ports: clk, reset (async, active-high); rx_flag/rx_data from the receiver,
//        clr_rx_flag back to it (low for one cycle per byte); rd_pop, ovr_clr and
//        irq_en from the bus side; rd_data (FIFO head or 0), status word, irq.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int NBIT       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = CeilLog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_flag,
    input  logic [NBIT-1:0] rx_data,
    output logic            clr_rx_flag,
    input  logic            rd_pop,
    input  logic            ovr_clr,
    input  logic            irq_en,
    output logic [31:0]     rd_data,
    output logic [31:0]     status,
    output logic            irq
);

    rx_state_t        state;
    logic             overrun;
    logic             push;
    logic             full;
    logic             empty;
    logic [NBIT-1:0]  head;
    logic [CNT_W-1:0] count;

    assign push = state == CAPTURE;

    uart_rx_fifo #(
        .NBIT      (NBIT),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (rd_pop),
        .wr_data(rx_data),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // clr_rx_flag is registered alongside the state: it drops exactly on entry to CLEAR
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= WAIT_FLAG;
            clr_rx_flag <= 1'b1;
        end else begin
            clr_rx_flag <= state != CAPTURE;
            case (state)
                WAIT_FLAG: state <= rx_flag ? CAPTURE : WAIT_FLAG;
                CAPTURE:   state <= CLEAR;
                CLEAR:     state <= WAIT_DROP;
                default:   state <= rx_flag ? WAIT_DROP : WAIT_FLAG;
            endcase
        end

    // A new overrun outranks a concurrent clear
    always_ff @(posedge clk or posedge reset)
        if (reset) overrun <= 1'b0;
        else if (push & full & ~rd_pop) overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;

    assign rd_data = empty ? '0 : 32'(head);
    assign irq     = ~empty & irq_en;

    always_comb begin
        status                        = '0;
        status[ST_NEMPTY]             = ~empty;
        status[ST_FULL]               = full;
        status[ST_OVR]                = overrun;
        status[ST_CNT_LSB +: CNT_W]   = count;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table vectors, handshake corner cases and a randomized model check
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_flag = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rd_pop = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        irq_en = 1'b0;
    logic        clr_rx_flag;
    logic        irq;
    logic [31:0] rd_data;
    logic [31:0] status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rx_flag    (rx_flag),
        .rx_data    (rx_data),
        .clr_rx_flag(clr_rx_flag),
        .rd_pop     (rd_pop),
        .ovr_clr    (ovr_clr),
        .irq_en     (irq_en),
        .rd_data    (rd_data),
        .status     (status),
        .irq        (irq)
    );

    typedef struct packed {
        logic        flag;
        logic [7:0]  data;
        logic        pop;
        logic        oclr;
        logic        ien;
        logic        e_clr;
        logic [31:0] e_stat;
        logic [31:0] e_rd;
        logic        e_irq;
    } vec_t;

    vec_t tbl [9];

    logic [7:0] mq [$];
    bit         movr;
    bit         armed;
    int         edge_no;
    int         det_edge;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_status(input int n, input bit o);
        return (32'(n) << 8) | (32'(o) << 2) | (32'(n == DEPTH) << 1) | 32'(n != 0);
    endfunction

    // Drives one complete receiver handshake; optional bus strobes land on the capture edge
    task automatic send_byte(input logic [7:0] d, input logic cp, input logic co);
        rx_flag = 1'b1;
        rx_data = d;
        @(negedge clk);
        rd_pop  = cp;
        ovr_clr = co;
        @(negedge clk);
        rd_pop  = 1'b0;
        ovr_clr = 1'b0;
        chk("send_clr_low", 32'(clr_rx_flag), 32'd0);
        rx_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pop_check(input logic [7:0] exp);
        chk("pop_head", rd_data, 32'(exp));
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_flag = 1'b0;
        rd_pop = 1'b0;
        ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lows;
        bit rbusy, rseen, push_now, overflow;
        int rhold, n;

        tbl[0] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000, 32'h00, 1'b0};
        tbl[1] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 32'h101, 32'h5A, 1'b1};
        tbl[2] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 32'h101, 32'h5A, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h101, 32'h5A, 1'b1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000, 32'h00, 1'b0};
        tbl[5] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000, 32'h00, 1'b0};
        tbl[6] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h101, 32'h3C, 1'b0};
        tbl[7] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 32'h101, 32'h3C, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h000, 32'h00, 1'b0};

        irq_en = 1'b1;
        @(negedge clk);
        chk("rst_clr", 32'(clr_rx_flag), 32'd1);
        chk("rst_status", status, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            rx_flag = tbl[i].flag;
            rx_data = tbl[i].data;
            rd_pop  = tbl[i].pop;
            ovr_clr = tbl[i].oclr;
            irq_en  = tbl[i].ien;
            @(negedge clk);
            chk("tbl_clr", 32'(clr_rx_flag), 32'(tbl[i].e_clr));
            chk("tbl_status", status, tbl[i].e_stat);
            chk("tbl_rd_data", rd_data, tbl[i].e_rd);
            chk("tbl_irq", 32'(irq), 32'(tbl[i].e_irq));
        end
        rx_flag = 1'b0;
        rd_pop  = 1'b0;
        ovr_clr = 1'b0;
        irq_en  = 1'b1;
        @(negedge clk);

        // Slow drop: flag stays high long after the clear pulse
        rx_flag = 1'b1;
        rx_data = 8'h77;
        @(negedge clk);
        @(negedge clk);
        chk("slow_clr_low", 32'(clr_rx_flag), 32'd0);
        lows = 0;
        repeat (10) begin
            @(negedge clk);
            if (!clr_rx_flag) lows++;
        end
        chk("slow_extra_clr", 32'(lows), 32'd0);
        chk("slow_status", status, 32'h101);
        rx_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("slow_status_after", status, 32'h101);
        pop_check(8'h77);
        chk("slow_empty", status, 32'd0);

        // Overflow with no pops
        for (int d = 1; d <= 5; d++) send_byte(8'(d), 1'b0, 1'b0);
        chk("ovf_status", status, 32'h407);
        for (int d = 1; d <= 4; d++) pop_check(8'(d));
        chk("ovf_rd_empty", rd_data, 32'd0);
        chk("ovf_sticky", status, 32'h004);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovf_cleared", status, 32'd0);

        // Full FIFO with push and pop on the same edge
        for (int d = 'h11; d <= 'h14; d++) send_byte(8'(d), 1'b0, 1'b0);
        chk("full_status", status, 32'h403);
        send_byte(8'h66, 1'b1, 1'b0);
        chk("pp_status", status, 32'h403);
        chk("pp_head", rd_data, 32'h12);
        pop_check(8'h12);
        pop_check(8'h13);
        pop_check(8'h14);
        pop_check(8'h66);
        chk("pp_empty", status, 32'd0);

        // Pop while empty
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
        chk("empty_pop_status", status, 32'd0);
        chk("empty_pop_rd", rd_data, 32'd0);

        // ovr_clr on the same edge as an overflow
        for (int d = 'h21; d <= 'h24; d++) send_byte(8'(d), 1'b0, 1'b0);
        send_byte(8'h25, 1'b0, 1'b1);
        chk("ovr_set_wins", status, 32'h407);
        for (int d = 'h21; d <= 'h24; d++) pop_check(8'(d));
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
        chk("ovr_empty_pop", status, 32'h004);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_final_clear", status, 32'd0);

        // Reset landing in the clear cycle
        rx_flag = 1'b1;
        rx_data = 8'h99;
        @(negedge clk);
        @(negedge clk);
        chk("rstc_clr_low", 32'(clr_rx_flag), 32'd0);
        reset = 1'b1;
        rx_flag = 1'b0;
        #1;
        chk("rstc_clr_high", 32'(clr_rx_flag), 32'd1);
        chk("rstc_status", status, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstc_rd", rd_data, 32'd0);
        send_byte(8'hA5, 1'b0, 1'b0);
        chk("rstc_recover", status, 32'h101);
        pop_check(8'hA5);

        // Randomized run against a timeline model of the handshake and FIFO
        do_reset();
        mq.delete();
        movr = 1'b0;
        armed = 1'b1;
        edge_no = 0;
        det_edge = -10;
        rbusy = 1'b0;
        rseen = 1'b0;
        rhold = 0;
        for (int c = 0; c < 3000; c++) begin
            n = mq.size();
            chk("rnd_rd_data", rd_data, n != 0 ? 32'(mq[0]) : 32'd0);
            chk("rnd_status", status, exp_status(n, movr));
            chk("rnd_irq", 32'(irq), 32'(n != 0 && irq_en));
            chk("rnd_clr", 32'(clr_rx_flag), 32'(!(!armed && edge_no == det_edge + 1)));
            if (!rbusy) begin
                rx_flag = $urandom_range(0, 2) == 0;
                rx_data = 8'($urandom);
                rbusy = rx_flag;
                rseen = 1'b0;
            end else begin
                if (!rseen && !clr_rx_flag) begin
                    rseen = 1'b1;
                    rhold = int'($urandom_range(0, 3));
                end
                if (rseen) begin
                    if (rhold == 0) begin
                        rx_flag = 1'b0;
                        rbusy = 1'b0;
                    end else rhold--;
                end
            end
            rd_pop  = c < 1500 ? $urandom_range(0, 11) == 0 : $urandom_range(0, 2) == 0;
            ovr_clr = $urandom_range(0, 9) == 0;
            irq_en  = $urandom_range(0, 7) != 0;
            @(posedge clk);
            edge_no++;
            push_now = 1'b0;
            if (armed) begin
                if (rx_flag) begin
                    armed = 1'b0;
                    det_edge = edge_no;
                end
            end else if (edge_no == det_edge + 1) push_now = 1'b1;
            else if (edge_no >= det_edge + 3 && !rx_flag) armed = 1'b1;
            overflow = push_now && mq.size() == DEPTH && !rd_pop;
            if (rd_pop && mq.size() > 0) void'(mq.pop_front());
            if (push_now && !overflow) mq.push_back(rx_data);
            movr = overflow ? 1'b1 : ovr_clr ? 1'b0 : movr;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
